// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the CPU controller: FSM states, opcode/sub-op values, legality check.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_WRITE_IMM = 3'd1,
        S_LOAD_A    = 3'd2,
        S_LOAD_B    = 3'd3,
        S_COMPUTE   = 3'd4,
        S_WRITE_REG = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] SHIFT_NONE = 2'b00;

    function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
        return (opcode == OPC_ALU) ||
               ((opcode == OPC_MOV) && ((op == MOV_REG) || (op == MOV_IMM)));
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Moore output decode: current state plus latched instruction fields -> datapath controls.
// err is only driven from TRAP when CTRL_ILLEGAL_TRAP_EN is defined.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  state_t            state_i,
    input  logic [2:0]        opcode_i,
    input  logic [1:0]        op_i,
    input  logic [REG_AW-1:0] rn_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [REG_AW-1:0] rm_i,
    input  logic [1:0]        shift_i,
    output logic              waiting_o,
    output logic              done_o,
    output logic              err_o,
    output logic              w_en_o,
    output logic              en_a_o,
    output logic              en_b_o,
    output logic              en_c_o,
    output logic              en_status_o,
    output logic              sel_a_o,
    output logic              sel_b_o,
    output logic              wb_sel_o,
    output logic [REG_AW-1:0] w_addr_o,
    output logic [REG_AW-1:0] r_addr_o,
    output logic [1:0]        shift_op_o,
    output logic [1:0]        alu_op_o
);

    logic is_mov;
    logic is_cmp;

    assign is_mov = (opcode_i == OPC_MOV);
    assign is_cmp = (opcode_i == OPC_ALU) && (op_i == ALU_CMP);

    always_comb begin
        waiting_o   = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        w_en_o      = 1'b0;
        en_a_o      = 1'b0;
        en_b_o      = 1'b0;
        en_c_o      = 1'b0;
        en_status_o = 1'b0;
        sel_a_o     = 1'b0;
        sel_b_o     = 1'b0;
        wb_sel_o    = 1'b0;
        w_addr_o    = '0;
        r_addr_o    = '0;
        shift_op_o  = SHIFT_NONE;
        alu_op_o    = ALU_ADD;
        case (state_i)
            S_WAIT: waiting_o = 1'b1;
            S_WRITE_IMM: begin
                wb_sel_o = 1'b1;
                w_addr_o = rn_i;
                w_en_o   = 1'b1;
                done_o   = 1'b1;
            end
            S_LOAD_A: begin
                r_addr_o = rn_i;
                en_a_o   = 1'b1;
            end
            S_LOAD_B: begin
                r_addr_o = rm_i;
                en_b_o   = 1'b1;
            end
            S_COMPUTE: begin
                shift_op_o = shift_i;
                // MOV reg is "0 + shifted Rm": force ADD and zero operand A.
                alu_op_o    = is_mov ? ALU_ADD : op_i;
                sel_a_o     = is_mov || (op_i == ALU_MVN);
                en_c_o      = !is_cmp;
                en_status_o = is_cmp;
                done_o      = is_cmp;
            end
            S_WRITE_REG: begin
                w_addr_o = rd_i;
                w_en_o   = 1'b1;
                done_o   = 1'b1;
            end
            S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                err_o = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: state register, field latch and next-state logic; outputs come from cpu_ctrl_decode.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal instructions lock the FSM in TRAP with err=1 until rst.
module cpu_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rm,
    input  logic [1:0]        shift,
    output logic              waiting,
    output logic              done,
    output logic              err,
    output logic              w_en,
    output logic              en_A,
    output logic              en_B,
    output logic              en_C,
    output logic              en_status,
    output logic              sel_A,
    output logic              sel_B,
    output logic              wb_sel,
    output logic [REG_AW-1:0] w_addr,
    output logic [REG_AW-1:0] r_addr,
    output logic [1:0]        shift_op,
    output logic [1:0]        ALU_op
);

    state_t            state_q, state_d;
    logic [2:0]        opcode_q;
    logic [1:0]        op_q;
    logic [REG_AW-1:0] rn_q, rd_q, rm_q;
    logic [1:0]        shift_q;
    logic              accept;

    assign accept = start && (state_q == S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_WAIT;
            opcode_q <= '0;
            op_q     <= '0;
            rn_q     <= '0;
            rd_q     <= '0;
            rm_q     <= '0;
            shift_q  <= SHIFT_NONE;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opcode_q <= opcode;
                op_q     <= op;
                rn_q     <= rn;
                rd_q     <= rd;
                rm_q     <= rm;
                shift_q  <= shift;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (start) begin
                    if (!is_legal(opcode, op)) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_WAIT;
`endif
                    end else if (opcode == OPC_MOV) begin
                        state_d = (op == MOV_IMM) ? S_WRITE_IMM : S_LOAD_B;
                    end else if (op == ALU_MVN) begin
                        state_d = S_LOAD_B;
                    end else begin
                        state_d = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A:    state_d = S_LOAD_B;
            S_LOAD_B:    state_d = S_COMPUTE;
            S_COMPUTE:   state_d = ((opcode_q == OPC_ALU) && (op_q == ALU_CMP)) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_WAIT;
        endcase
    end

    cpu_ctrl_decode #(
        .REG_AW(REG_AW)
    ) u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_q),
        .op_i        (op_q),
        .rn_i        (rn_q),
        .rd_i        (rd_q),
        .rm_i        (rm_q),
        .shift_i     (shift_q),
        .waiting_o   (waiting),
        .done_o      (done),
        .err_o       (err),
        .w_en_o      (w_en),
        .en_a_o      (en_A),
        .en_b_o      (en_B),
        .en_c_o      (en_C),
        .en_status_o (en_status),
        .sel_a_o     (sel_A),
        .sel_b_o     (sel_B),
        .wb_sel_o    (wb_sel),
        .w_addr_o    (w_addr),
        .r_addr_o    (r_addr),
        .shift_op_o  (shift_op),
        .alu_op_o    (ALU_op)
    );

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench: cpu_controller driving a small behavioural 16-bit datapath; every cycle's controls are checked.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  shift;
    logic        waiting, done, err, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, wb_sel;
    logic [2:0]  w_addr, r_addr;
    logic [1:0]  shift_op, ALU_op;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_controller #(.REG_AW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .op(op),
        .rn(rn), .rd(rd), .rm(rm), .shift(shift),
        .waiting(waiting), .done(done), .err(err), .w_en(w_en),
        .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
        .sel_A(sel_A), .sel_B(sel_B), .wb_sel(wb_sel),
        .w_addr(w_addr), .r_addr(r_addr), .shift_op(shift_op), .ALU_op(ALU_op)
    );

    // Behavioural datapath: register file, A/B/C registers, shifter on B, ALU, Z flag.
    logic [15:0] rf [8];
    logic [15:0] a_q, b_q, c_q, datapath_in, sh_b, ain, alu;
    logic        z_q, dp_clr;

    always_comb begin
        sh_b = b_q;
        case (shift_op)
            2'b01: sh_b = {b_q[14:0], 1'b0};
            2'b10: sh_b = {1'b0, b_q[15:1]};
            2'b11: sh_b = {b_q[15], b_q[15:1]};
            default: sh_b = b_q;
        endcase
        ain = sel_A ? 16'd0 : a_q;
        alu = 16'd0;
        case (ALU_op)
            2'b00: alu = ain + sh_b;
            2'b01: alu = ain - sh_b;
            2'b10: alu = ain & sh_b;
            default: alu = ~sh_b;
        endcase
    end

    always @(posedge clk) begin
        if (dp_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'd0;
            a_q <= 16'd0; b_q <= 16'd0; c_q <= 16'd0; z_q <= 1'b0;
        end else begin
            if (w_en) rf[w_addr] <= wb_sel ? datapath_in : c_q;
            if (en_A) a_q <= rf[r_addr];
            if (en_B) b_q <= rf[r_addr];
            if (en_C) c_q <= alu;
            if (en_status) z_q <= (alu == 16'd0);
        end
    end

    logic [20:0] outs;
    assign outs = {waiting, done, err, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, wb_sel,
                   w_addr, r_addr, shift_op, ALU_op};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] ctl(input logic wt, dn, er, we, ea, eb, ec, es, sa, sb, wb,
                                        input logic [2:0] wa, ra, input logic [1:0] sh, al);
        return {wt, dn, er, we, ea, eb, ec, es, sa, sb, wb, wa, ra, sh, al};
    endfunction

    function automatic logic [20:0] v_wait();
        return ctl(1,0,0,0,0,0,0,0,0,0,0, 3'd0, 3'd0, 2'd0, 2'd0);
    endfunction
    function automatic logic [20:0] v_imm(input logic [2:0] a);
        return ctl(0,1,0,1,0,0,0,0,0,0,1, a, 3'd0, 2'd0, 2'd0);
    endfunction
    function automatic logic [20:0] v_la(input logic [2:0] a);
        return ctl(0,0,0,0,1,0,0,0,0,0,0, 3'd0, a, 2'd0, 2'd0);
    endfunction
    function automatic logic [20:0] v_lb(input logic [2:0] a);
        return ctl(0,0,0,0,0,1,0,0,0,0,0, 3'd0, a, 2'd0, 2'd0);
    endfunction
    function automatic logic [20:0] v_wr(input logic [2:0] a);
        return ctl(0,1,0,1,0,0,0,0,0,0,0, a, 3'd0, 2'd0, 2'd0);
    endfunction

    task automatic step(input string tag, input logic [20:0] exp);
        @(negedge clk);
        check(tag, {11'd0, outs}, {11'd0, exp});
    endtask

    // Called at a negedge; presents one instruction for one accepting edge, then scrambles the fields.
    task automatic issue(input string name, input logic [2:0] opc, input logic [1:0] o,
                         input logic [2:0] n, d, m, input logic [1:0] s);
        $display("TX %s opcode=%b op=%b rn=%0d rd=%0d rm=%0d shift=%b", name, opc, o, n, d, m, s);
        opcode = opc; op = o; rn = n; rd = d; rm = m; shift = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        opcode = 3'b101; op = 2'b01; rn = 3'd7; rd = 3'd7; rm = 3'd7; shift = 2'b11;
    endtask

    initial begin
        rst = 1'b1; dp_clr = 1'b1; start = 1'b0;
        opcode = 3'b000; op = 2'b00; rn = 3'd0; rd = 3'd0; rm = 3'd0; shift = 2'b00;
        datapath_in = 16'd0;
        repeat (2) @(posedge clk);
        step("reset", v_wait());
        rst = 1'b0; dp_clr = 1'b0;

        datapath_in = 16'd9;
        issue("MOV R0,#9", 3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 2'b00);
        step("movimm0_write", v_imm(3'd0));
        step("movimm0_wait", v_wait());
        datapath_in = 16'd8;
        issue("MOV R1,#8", 3'b110, 2'b10, 3'd1, 3'd0, 3'd0, 2'b00);
        step("movimm1_write", v_imm(3'd1));
        step("movimm1_wait", v_wait());
        check("r0", {16'd0, rf[0]}, 32'd9);
        check("r1", {16'd0, rf[1]}, 32'd8);

        issue("ADD R2,R0,R1", 3'b101, 2'b00, 3'd0, 3'd2, 3'd1, 2'b00);
        step("add_load_a", v_la(3'd0));
        step("add_load_b", v_lb(3'd1));
        step("add_compute", ctl(0,0,0,0,0,0,1,0,0,0,0, 3'd0, 3'd0, 2'b00, 2'b00));
        step("add_write", v_wr(3'd2));
        step("add_wait", v_wait());
        check("r2_sum", {16'd0, rf[2]}, 32'd17);

        issue("CMP R0,R0", 3'b101, 2'b01, 3'd0, 3'd5, 3'd0, 2'b00);
        step("cmp_load_a", v_la(3'd0));
        step("cmp_load_b", v_lb(3'd0));
        step("cmp_compute", ctl(0,1,0,0,0,0,0,1,0,0,0, 3'd0, 3'd0, 2'b00, 2'b01));
        step("cmp_wait", v_wait());
        check("cmp_z", {31'd0, z_q}, 32'd1);
        check("cmp_no_write", {16'd0, rf[5]}, 32'd0);

        issue("MOV R3,R1,LSL", 3'b110, 2'b00, 3'd6, 3'd3, 3'd1, 2'b01);
        step("movreg_load_b", v_lb(3'd1));
        step("movreg_compute", ctl(0,0,0,0,0,0,1,0,1,0,0, 3'd0, 3'd0, 2'b01, 2'b00));
        step("movreg_write", v_wr(3'd3));
        step("movreg_wait", v_wait());
        check("r3_lsl", {16'd0, rf[3]}, 32'd16);

        issue("MVN R4,R1", 3'b101, 2'b11, 3'd2, 3'd4, 3'd1, 2'b00);
        step("mvn_load_b", v_lb(3'd1));
        step("mvn_compute", ctl(0,0,0,0,0,0,1,0,1,0,0, 3'd0, 3'd0, 2'b00, 2'b11));
        step("mvn_write", v_wr(3'd4));
        step("mvn_wait", v_wait());
        check("r4_mvn", {16'd0, rf[4]}, 32'h0000FFF7);

        // start held high: a fresh instruction each time WAIT is re-entered.
        $display("TX MOV R5,#3 with start held");
        datapath_in = 16'd3;
        opcode = 3'b110; op = 2'b10; rn = 3'd5; start = 1'b1;
        step("held_write1", v_imm(3'd5));
        step("held_wait", v_wait());
        step("held_write2", v_imm(3'd5));
        start = 1'b0;
        step("held_idle", v_wait());
        check("r5_imm", {16'd0, rf[5]}, 32'd3);

        // start during a busy instruction is dropped.
        issue("ADD R6,R0,R1 (busy start)", 3'b101, 2'b00, 3'd0, 3'd6, 3'd1, 2'b00);
        step("busy_load_a", v_la(3'd0));
        opcode = 3'b110; op = 2'b10; rn = 3'd7; start = 1'b1;
        step("busy_load_b", v_lb(3'd1));
        step("busy_compute", ctl(0,0,0,0,0,0,1,0,0,0,0, 3'd0, 3'd0, 2'b00, 2'b00));
        start = 1'b0;
        step("busy_write", v_wr(3'd6));
        step("busy_wait", v_wait());
        check("r6_sum", {16'd0, rf[6]}, 32'd17);
        check("r7_untouched", {16'd0, rf[7]}, 32'd0);

        // Reset in LOAD_B aborts the instruction; R2 must keep 17 rather than 9&8.
        issue("AND R2,R0,R1 (reset abort)", 3'b101, 2'b10, 3'd0, 3'd2, 3'd1, 2'b00);
        step("abort_load_a", v_la(3'd0));
        step("abort_load_b", v_lb(3'd1));
        rst = 1'b1;
        step("abort_reset", v_wait());
        rst = 1'b0;
        step("abort_after", v_wait());
        step("abort_idle", v_wait());
        check("r2_kept", {16'd0, rf[2]}, 32'd17);

`ifdef CTRL_ILLEGAL_TRAP_EN
        issue("ILLEGAL opcode 000", 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
        step("trap_enter", ctl(0,0,1,0,0,0,0,0,0,0,0, 3'd0, 3'd0, 2'd0, 2'd0));
        opcode = 3'b110; op = 2'b10; rn = 3'd7; start = 1'b1;
        step("trap_hold1", ctl(0,0,1,0,0,0,0,0,0,0,0, 3'd0, 3'd0, 2'd0, 2'd0));
        step("trap_hold2", ctl(0,0,1,0,0,0,0,0,0,0,0, 3'd0, 3'd0, 2'd0, 2'd0));
        start = 1'b0;
        check("trap_no_write", {16'd0, rf[7]}, 32'd0);
        rst = 1'b1;
        step("trap_reset", v_wait());
        rst = 1'b0;
        step("trap_cleared", v_wait());
`else
        issue("ILLEGAL opcode 000", 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00);
        step("illegal_opc", v_wait());
        issue("ILLEGAL MOV op 01", 3'b110, 2'b01, 3'd7, 3'd7, 3'd7, 2'b00);
        step("illegal_mov", v_wait());
        step("illegal_idle", v_wait());
        check("illegal_no_write", {16'd0, rf[7]}, 32'd0);
`endif

        datapath_in = 16'd1;
        issue("MOV R7,#1", 3'b110, 2'b10, 3'd7, 3'd0, 3'd0, 2'b00);
        step("final_write", v_imm(3'd7));
        step("final_wait", v_wait());
        check("r7_imm", {16'd0, rf[7]}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
